// File: rtl/jtcop_objdma.sv
// Object RAM -> object line-buffer copy sequencer, started by the CPU *DM strobe.
// Define JTCOP_OBJDMA_IMMEDIATE_EN to start copies at once instead of waiting for vertical blank.
module jtcop_objdma #(
    parameter int AW = 10
) (
    input  logic          rst,
    input  logic          clk,
    input  logic          cen,
    input  logic          LVBL,
    input  logic          obj_copy,
    input  logic          cpu_obj_cs,
    output logic          dma_sel,
    output logic [AW-1:0] dma_addr,
    input  logic [15:0]   ram_dout,
    output logic [AW-1:0] buf_addr,
    output logic [15:0]   buf_din,
    output logic          buf_we,
    output logic          busy,
    output logic          done,
    output logic          overrun
);
    typedef enum logic [1:0] {IDLE, ARMED, READ, WRITE} state_t;

    state_t        state_q;
    logic [AW-1:0] dma_addr_q, buf_addr_q;
    logic          buf_we_q, done_q, overrun_q, pend_q, lvbl_l_q, vb_hold_q;
    logic          vb_start, copying;

    assign vb_start = lvbl_l_q & ~LVBL;
    assign copying  = (state_q == READ) || (state_q == WRITE);

`ifdef JTCOP_OBJDMA_IMMEDIATE_EN
    localparam state_t START_ST = READ;
`else
    localparam state_t START_ST = ARMED;
    logic lvbl_rise;
    assign lvbl_rise = LVBL & ~lvbl_l_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            dma_addr_q <= '0;
            buf_addr_q <= '0;
            buf_we_q   <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
            pend_q     <= 1'b0;
            lvbl_l_q   <= 1'b0;
            vb_hold_q  <= 1'b0;
        end else begin
            lvbl_l_q <= LVBL;
            buf_we_q <= 1'b0;
            done_q   <= 1'b0;
            // a blank edge seen while cen is low must survive until the next enabled cycle
            if (cen)
                vb_hold_q <= 1'b0;
            else if (state_q == ARMED && vb_start)
                vb_hold_q <= 1'b1;
`ifndef JTCOP_OBJDMA_IMMEDIATE_EN
            if (copying && lvbl_rise)
                overrun_q <= 1'b1;
`endif
            if (copying && obj_copy)
                pend_q <= 1'b1;
            case (state_q)
                IDLE: if (obj_copy) begin
                    overrun_q  <= 1'b0;
                    dma_addr_q <= '0;
                    state_q    <= START_ST;
                end
                ARMED: if (cen && (vb_start || vb_hold_q)) begin
                    dma_addr_q <= '0;
                    state_q    <= READ;
                end
                READ: if (cen && !cpu_obj_cs) begin
                    buf_we_q   <= 1'b1;
                    buf_addr_q <= dma_addr_q;
                    state_q    <= WRITE;
                end
                WRITE: if (cen) begin
                    dma_addr_q <= dma_addr_q + AW'(1);
                    if (&dma_addr_q) begin
                        done_q <= 1'b1;
                        // a request that arrived during the copy re-arms straight away
                        if (pend_q || obj_copy) begin
                            pend_q  <= 1'b0;
                            state_q <= START_ST;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        state_q <= READ;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // RAM output is already a registered value one clk after the address, so it feeds the buffer directly
    assign buf_din  = buf_we_q ? ram_dout : 16'h0;
    assign buf_we   = buf_we_q;
    assign buf_addr = buf_addr_q;
    assign dma_addr = dma_addr_q;
    assign dma_sel  = copying;
    assign busy     = state_q != IDLE;
    assign done     = done_q;
    assign overrun  = overrun_q;
endmodule

// File: tb/tb_jtcop_objdma.sv
// Directed bench for jtcop_objdma: full copies, CPU contention, re-arm, overrun, reset abort, cen hold-off.
module tb_jtcop_objdma;
    localparam int AW = 10;
    localparam logic [AW-1:0] CPU_A = 10'h3A5;

    logic          rst, clk, cen, LVBL, obj_copy, cpu_obj_cs;
    logic          dma_sel, buf_we, busy, done, overrun;
    logic [AW-1:0] dma_addr, buf_addr;
    logic [15:0]   ram_dout, buf_din;

    int n_cmp = 0, n_bad = 0, cyc = 0;
    int wr_cnt, seq_err, data_err, done_cnt, first_we_cyc, vb_cyc, snap;
    logic [AW-1:0] exp_next;
    logic busy_at_done, mon_clr;

    jtcop_objdma #(.AW(AW)) dut (
        .rst(rst), .clk(clk), .cen(cen), .LVBL(LVBL), .obj_copy(obj_copy),
        .cpu_obj_cs(cpu_obj_cs), .dma_sel(dma_sel), .dma_addr(dma_addr),
        .ram_dout(ram_dout), .buf_addr(buf_addr), .buf_din(buf_din),
        .buf_we(buf_we), .busy(busy), .done(done), .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] memf(input logic [AW-1:0] a);
        return (16'({6'd0, a}) * 16'd40503) ^ 16'h5A5A;
    endfunction

    // object RAM: registered read, CPU address has priority over the DMA address
    always @(posedge clk)
        ram_dout <= memf(cpu_obj_cs ? CPU_A : (dma_sel ? dma_addr : '0));

    always @(negedge clk) begin
        if (mon_clr) begin
            wr_cnt <= 0; seq_err <= 0; data_err <= 0; done_cnt <= 0;
            first_we_cyc <= -1; exp_next <= '0; busy_at_done <= 1'b1;
        end else begin
            if (buf_we) begin
                if (buf_addr !== exp_next) seq_err <= seq_err + 1;
                if (buf_din !== memf(buf_addr)) data_err <= data_err + 1;
                if (wr_cnt == 0) first_we_cyc <= cyc;
                exp_next <= buf_addr + 1'b1;
                wr_cnt <= wr_cnt + 1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                busy_at_done <= busy;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk); #1;
        mon_clr = 1'b0;
    endtask

    task automatic pulse_copy();
        obj_copy = 1'b1; tick(); obj_copy = 1'b0;
    endtask

    task automatic wait_done(output bit to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (done === 1'b1) begin to = 1'b0; break; end
        end
        tick();
    endtask

    task automatic wait_we_at(input logic [AW-1:0] a, output bit to);
        to = 1'b1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (buf_we === 1'b1 && buf_addr === a) begin to = 1'b0; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; cen = 1'b1; LVBL = 1'b1; obj_copy = 1'b0; cpu_obj_cs = 1'b0; mon_clr = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if ({busy, dma_sel, buf_we, done, overrun} !== 5'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 00000", {busy, dma_sel, buf_we, done, overrun}); end
        n_cmp++; if (dma_addr !== '0) begin n_bad++; $display("FAIL reset_dma_addr: got %h want 000", dma_addr); end
        n_cmp++; if ({buf_addr, buf_din} !== '0) begin n_bad++; $display("FAIL reset_buf: got %h/%h want 0/0", buf_addr, buf_din); end
        tick(); rst = 1'b0; tick();
        clear_mon();
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        bit to;
        tick(); pulse_copy();
        n_cmp++; if ({busy, dma_sel} !== 2'b10) begin n_bad++; $display("FAIL armed_flags: got %b want 10", {busy, dma_sel}); end
        repeat (10) tick();
        n_cmp++; if (wr_cnt !== 0) begin n_bad++; $display("FAIL armed_waits: got %0d writes want 0", wr_cnt); end
        LVBL = 1'b0; vb_cyc = cyc;
        wait_done(to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL basic_timeout: got %b want 0", to); end
        n_cmp++; if (first_we_cyc - vb_cyc !== 2) begin n_bad++; $display("FAIL basic_latency: got %0d want 2", first_we_cyc - vb_cyc); end
        n_cmp++; if (wr_cnt !== 1024) begin n_bad++; $display("FAIL basic_count: got %0d want 1024", wr_cnt); end
        n_cmp++; if (seq_err !== 0) begin n_bad++; $display("FAIL basic_addr_seq: got %0d errors want 0", seq_err); end
        n_cmp++; if (data_err !== 0) begin n_bad++; $display("FAIL basic_data: got %0d errors want 0", data_err); end
        n_cmp++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        n_cmp++; if (busy_at_done !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done: got %b want 0", busy_at_done); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL basic_overrun: got %b want 0", overrun); end
        LVBL = 1'b1; tick(); tick();
    endtask

    task automatic test_contention();
        bit to; int hold_err;
        clear_mon(); tick(); pulse_copy(); LVBL = 1'b0;
        to = 1'b1;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (dma_sel === 1'b1 && buf_we === 1'b0 && dma_addr === 10'h10) begin to = 1'b0; break; end
        end
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL cont_reach_0x10: got timeout %b want 0", to); end
        cpu_obj_cs = 1'b1;
        hold_err = 0;
        repeat (5) begin
            @(posedge clk); @(negedge clk);
            if (buf_we !== 1'b0 || dma_addr !== 10'h10 || dma_sel !== 1'b1) hold_err++;
        end
        cpu_obj_cs = 1'b0;
        n_cmp++; if (hold_err !== 0) begin n_bad++; $display("FAIL cont_hold: got %0d bad clks want 0", hold_err); end
        wait_done(to);
        n_cmp++; if (wr_cnt !== 1024) begin n_bad++; $display("FAIL cont_count: got %0d want 1024", wr_cnt); end
        n_cmp++; if (seq_err !== 0 || data_err !== 0) begin n_bad++; $display("FAIL cont_seq_data: got %0d/%0d want 0/0", seq_err, data_err); end
        LVBL = 1'b1; tick(); tick();
    endtask

    task automatic test_pending();
        bit to;
        clear_mon(); tick(); pulse_copy(); LVBL = 1'b0;
        wait_we_at(10'h200, to);
        obj_copy = 1'b1; tick(); obj_copy = 1'b0;
        wait_done(to);
        n_cmp++; if (to !== 1'b0) begin n_bad++; $display("FAIL pend_timeout: got %b want 0", to); end
        n_cmp++; if (wr_cnt !== 1024 || done_cnt !== 1) begin n_bad++; $display("FAIL pend_first_copy: got %0d writes %0d done want 1024 1", wr_cnt, done_cnt); end
        n_cmp++; if ({busy, dma_sel} !== 2'b10) begin n_bad++; $display("FAIL pend_armed: got %b want 10", {busy, dma_sel}); end
        repeat (20) tick();
        n_cmp++; if (wr_cnt !== 1024) begin n_bad++; $display("FAIL pend_waits_vb: got %0d want 1024", wr_cnt); end
        LVBL = 1'b1; repeat (3) tick();
        clear_mon(); tick();
        LVBL = 1'b0; vb_cyc = cyc;
        wait_done(to);
        n_cmp++; if (first_we_cyc - vb_cyc !== 2) begin n_bad++; $display("FAIL pend_latency: got %0d want 2", first_we_cyc - vb_cyc); end
        n_cmp++; if (wr_cnt !== 1024 || data_err !== 0) begin n_bad++; $display("FAIL pend_second_copy: got %0d writes %0d errs want 1024 0", wr_cnt, data_err); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL pend_idle_after: got %b want 0", busy); end
        LVBL = 1'b1; tick(); tick();
    endtask

    task automatic test_overrun();
        bit to;
        clear_mon(); tick(); pulse_copy(); LVBL = 1'b0;
        wait_we_at(10'h300, to);
        LVBL = 1'b1;
        @(negedge clk);
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set: got %b want 1", overrun); end
        wait_done(to);
        n_cmp++; if (wr_cnt !== 1024 || seq_err !== 0) begin n_bad++; $display("FAIL ovr_completes: got %0d writes %0d seq errs want 1024 0", wr_cnt, seq_err); end
        n_cmp++; if (overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
        pulse_copy();
        n_cmp++; if ({overrun, busy} !== 2'b01) begin n_bad++; $display("FAIL ovr_clear: got %b want 01", {overrun, busy}); end
    endtask

    task automatic test_reset_mid();
        bit to;
        clear_mon(); tick(); LVBL = 1'b0;
        wait_we_at(10'h100, to);
        rst = 1'b1; #1;
        n_cmp++; if ({busy, dma_sel, buf_we, done, overrun} !== 5'b0) begin n_bad++; $display("FAIL rmid_flags: got %b want 00000", {busy, dma_sel, buf_we, done, overrun}); end
        n_cmp++; if ({dma_addr, buf_addr, buf_din} !== '0) begin n_bad++; $display("FAIL rmid_addr_data: got %h/%h/%h want 0", dma_addr, buf_addr, buf_din); end
        tick(); rst = 1'b0; tick();
        snap = wr_cnt;
        repeat (30) tick();
        n_cmp++; if (wr_cnt !== snap || busy !== 1'b0) begin n_bad++; $display("FAIL rmid_no_resume: got %0d writes busy %b want %0d 0", wr_cnt, busy, snap); end
        pulse_copy();
        repeat (20) tick();
        n_cmp++; if (wr_cnt !== snap || busy !== 1'b1) begin n_bad++; $display("FAIL rmid_needs_vb: got %0d writes busy %b want %0d 1", wr_cnt, busy, snap); end
        LVBL = 1'b1; tick(); tick();
        clear_mon(); tick();
        LVBL = 1'b0; cen = 1'b0; vb_cyc = cyc;
        tick(); tick();
        n_cmp++; if (dma_sel !== 1'b0) begin n_bad++; $display("FAIL cen_hold_armed: got %b want 0", dma_sel); end
        tick(); cen = 1'b1;
        wait_done(to);
        n_cmp++; if (first_we_cyc - vb_cyc !== 5) begin n_bad++; $display("FAIL cen_held_vb_latency: got %0d want 5", first_we_cyc - vb_cyc); end
        n_cmp++; if (wr_cnt !== 1024 || data_err !== 0) begin n_bad++; $display("FAIL cen_copy: got %0d writes %0d errs want 1024 0", wr_cnt, data_err); end
    endtask

    task automatic test_immediate();
        bit to; int oc_cyc;
        clear_mon(); tick();
        obj_copy = 1'b1; oc_cyc = cyc; tick(); obj_copy = 1'b0;
        repeat (20) tick();
        LVBL = 1'b0; repeat (5) tick(); LVBL = 1'b1;
        wait_done(to);
        n_cmp++; if (first_we_cyc - oc_cyc !== 2) begin n_bad++; $display("FAIL imm_latency: got %0d want 2", first_we_cyc - oc_cyc); end
        n_cmp++; if (wr_cnt !== 1024 || data_err !== 0) begin n_bad++; $display("FAIL imm_copy: got %0d writes %0d errs want 1024 0", wr_cnt, data_err); end
        n_cmp++; if (overrun !== 1'b0) begin n_bad++; $display("FAIL imm_overrun: got %b want 0", overrun); end
    endtask

    initial begin
        test_reset();
`ifdef JTCOP_OBJDMA_IMMEDIATE_EN
        test_immediate();
`else
        test_basic();
        test_contention();
        test_pending();
        test_overrun();
        test_reset_mid();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
